noc_local_vc_arbiter: RTL and testbench

Packet-level arbiter that shares one NoC node's sender port between two local injection channels (channel0, channel1). It sits between the local processing element and the router's sender port of a mesh node (e.g. node 0_0). Once a header flit is granted, the winning channel owns the port until its tail flit transfers. Grants alternate round-robin per packet, and the output is registered.

---
 rtl/noc_local_vc_arbiter.sv | 139 +++++++++++++
 tb/tb_noc_local_vc_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_vc_arbiter.sv
// Packet-level round-robin arbiter sharing one router sender port between two local channels.
// A granted channel owns the registered output stage until its tail flit is accepted.
module noc_local_vc_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst_n,
    input  logic                  ch0_valid,
    output logic                  ch0_ready,
    input  logic [DATA_WIDTH-1:0] ch0_flit,
    input  logic                  ch0_is_header,
    input  logic                  ch0_is_tail,
    input  logic                  ch1_valid,
    output logic                  ch1_ready,
    input  logic [DATA_WIDTH-1:0] ch1_flit,
    input  logic                  ch1_is_header,
    input  logic                  ch1_is_tail,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic                  out_is_header,
    output logic                  out_is_tail,
    input  logic                  out_VCready,
    output logic                  owner,
    output logic                  busy,
    output logic                  orphan_err,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1
);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_flit_q, out_flit_d;
    logic                  out_hdr_q, out_hdr_d;
    logic                  out_tail_q, out_tail_d;
    logic                  orphan_q, orphan_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0]  cnt1_q, cnt1_d;

    logic req0, req1, slot_free;

    assign req0      = ch0_valid && ch0_is_header;
    assign req1      = ch1_valid && ch1_is_header;
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q && !out_ready;
        out_flit_d  = out_flit_q;
        out_hdr_d   = out_hdr_q;
        out_tail_d  = out_tail_q;
        orphan_d    = 1'b0;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        ch0_ready   = 1'b0;
        ch1_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Non-header flits arriving outside a packet are swallowed and flagged.
                ch0_ready = ch0_valid && !ch0_is_header;
                ch1_ready = ch1_valid && !ch1_is_header;
                orphan_d  = ch0_ready || ch1_ready;
                if (out_VCready && (req0 || req1)) begin
                    state_d = (req1 && (!req0 || rr_q)) ? StLock1 : StLock0;
                end
            end
            StLock0: begin
                ch0_ready = slot_free;
                if (ch0_valid && slot_free) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = ch0_flit;
                    out_hdr_d   = ch0_is_header;
                    out_tail_d  = ch0_is_tail;
                    if (ch0_is_tail) begin
                        state_d = StIdle;
                        rr_d    = 1'b1;
                        cnt0_d  = cnt0_q + CNT_WIDTH'(1);
                    end
                end
            end
            StLock1: begin
                ch1_ready = slot_free;
                if (ch1_valid && slot_free) begin
                    out_valid_d = 1'b1;
                    out_flit_d  = ch1_flit;
                    out_hdr_d   = ch1_is_header;
                    out_tail_d  = ch1_is_tail;
                    if (ch1_is_tail) begin
                        state_d = StIdle;
                        rr_d    = 1'b0;
                        cnt1_d  = cnt1_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= StIdle;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_hdr_q   <= 1'b0;
            out_tail_q  <= 1'b0;
            orphan_q    <= 1'b0;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_hdr_q   <= out_hdr_d;
            out_tail_q  <= out_tail_d;
            orphan_q    <= orphan_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_flit      = out_flit_q;
    assign out_is_header = out_hdr_q;
    assign out_is_tail   = out_tail_q;
    assign busy          = (state_q != StIdle);
    assign owner         = (state_q == StLock1);
    assign orphan_err    = orphan_q;
    assign pkt_cnt0      = cnt0_q;
    assign pkt_cnt1      = cnt1_q;

endmodule

// File: tb/tb_noc_local_vc_arbiter.sv
// Bench for noc_local_vc_arbiter: cycle vector table, directed corner sequences and a
// randomized run checked against a packet-order model.
module tb_noc_local_vc_arbiter;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        ch0_valid = 1'b0, ch0_ready, ch0_is_header = 1'b0, ch0_is_tail = 1'b0;
    logic        ch1_valid = 1'b0, ch1_ready, ch1_is_header = 1'b0, ch1_is_tail = 1'b0;
    logic [31:0] ch0_flit = '0, ch1_flit = '0, out_flit;
    logic        out_valid, out_ready = 1'b0, out_is_header, out_is_tail, out_VCready = 1'b0;
    logic        owner, busy, orphan_err;
    logic [7:0]  pkt_cnt0, pkt_cnt1;

    always #5 noc_clk = ~noc_clk;

    noc_local_vc_arbiter #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
        .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
        .ch0_valid(ch0_valid), .ch0_ready(ch0_ready), .ch0_flit(ch0_flit),
        .ch0_is_header(ch0_is_header), .ch0_is_tail(ch0_is_tail),
        .ch1_valid(ch1_valid), .ch1_ready(ch1_ready), .ch1_flit(ch1_flit),
        .ch1_is_header(ch1_is_header), .ch1_is_tail(ch1_is_tail),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
        .out_is_header(out_is_header), .out_is_tail(out_is_tail), .out_VCready(out_VCready),
        .owner(owner), .busy(busy), .orphan_err(orphan_err),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    typedef struct {
        logic c0v; logic [31:0] c0f; logic c0h; logic c0t;
        logic c1v; logic [31:0] c1f; logic c1h; logic c1t;
        logic ordy; logic vc;
        logic r0; logic r1; logic ov; logic [31:0] f; logic h; logic t;
        logic bsy; logic own; logic orph; logic [7:0] n0; logic [7:0] n1;
    } vec_t;

    typedef struct packed {logic [31:0] f; logic h; logic t;} flit_t;

    flit_t q0[$], q1[$], obs[$], ex[$];
    int unsigned vpct = 100, orpct = 100, vcpct = 100;
    logic s_r0, s_r1, s_orph, acc0, acc1;
    logic [7:0] s_c0, s_c1;

    function automatic flit_t mk(input logic [31:0] f, input logic h, input logic t);
        flit_t r;
        r.f = f; r.h = h; r.t = t;
        return r;
    endfunction

    // One clock: drive channel heads at negedge, sample just after, retire on posedge.
    task automatic tick();
        flit_t h0, h1;
        @(negedge noc_clk);
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        ch0_valid = (q0.size() > 0) && (h0.h || ($urandom_range(99) < vpct));
        ch1_valid = (q1.size() > 0) && (h1.h || ($urandom_range(99) < vpct));
        ch0_flit = h0.f; ch0_is_header = h0.h; ch0_is_tail = h0.t;
        ch1_flit = h1.f; ch1_is_header = h1.h; ch1_is_tail = h1.t;
        out_ready   = ($urandom_range(99) < orpct);
        out_VCready = ($urandom_range(99) < vcpct);
        #1;
        s_r0 = ch0_ready; s_r1 = ch1_ready; s_orph = orphan_err;
        s_c0 = pkt_cnt0; s_c1 = pkt_cnt1;
        acc0 = ch0_valid && ch0_ready;
        acc1 = ch1_valid && ch1_ready;
        if (out_valid && out_ready) obs.push_back(mk(out_flit, out_is_header, out_is_tail));
        @(posedge noc_clk);
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
    endtask

    task automatic do_reset();
        @(negedge noc_clk);
        noc_rst_n = 1'b0;
        ch0_valid = 1'b0; ch1_valid = 1'b0; out_ready = 1'b0; out_VCready = 1'b0;
        q0.delete(); q1.delete(); obs.delete(); ex.delete();
        repeat (2) @(negedge noc_clk);
        noc_rst_n = 1'b1;
    endtask

    task automatic check_stream(input string name);
        chk({name, "_nflits"}, obs.size(), ex.size());
        for (int i = 0; i < ex.size(); i++) begin
            if (i < obs.size()) chk($sformatf("%s_flit%0d", name, i), obs[i], ex[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[32];
        int first, n, pre;
        logic early, seen, orph_seen;

        //           c0v c0f  h t  c1v c1f  h t  ord vc | r0 r1 ov f   h t  bsy own orph n0 n1
        tbl[0]  = '{1, 'hA0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'h0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 'hA0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 'h0, 0, 0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 'hA1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 'hA0, 1, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 'hA2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 'hA1, 0, 0, 1, 0, 0, 0, 0};
        tbl[4]  = '{1, 'hA3, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 'hA2, 0, 0, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hA3, 0, 1, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hA3, 0, 1, 0, 0, 0, 1, 0};
        tbl[7]  = '{1, 'h77, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 'hA3, 0, 1, 0, 0, 0, 1, 0};
        tbl[8]  = '{1, 'h55, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hA3, 0, 1, 0, 0, 1, 1, 0};
        tbl[9]  = '{1, 'h55, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 'hA3, 0, 1, 1, 0, 0, 1, 0};
        tbl[10] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'h55, 1, 1, 0, 0, 0, 2, 0};
        for (int i = 11; i < 16; i++)
            tbl[i] = '{0, 'h0, 0, 0, 1, 'hC0, 1, 0, 1, 0, 0, 0, 0, 'h55, 1, 1, 0, 0, 0, 2, 0};
        tbl[16] = '{0, 'h0, 0, 0, 1, 'hC0, 1, 0, 1, 1, 0, 0, 0, 'h55, 1, 1, 0, 0, 0, 2, 0};
        tbl[17] = '{0, 'h0, 0, 0, 1, 'hC0, 1, 0, 1, 1, 0, 1, 0, 'h55, 1, 1, 1, 1, 0, 2, 0};
        tbl[18] = '{0, 'h0, 0, 0, 1, 'hC1, 0, 0, 1, 0, 0, 1, 1, 'hC0, 1, 0, 1, 1, 0, 2, 0};
        tbl[19] = '{0, 'h0, 0, 0, 1, 'hC2, 0, 1, 1, 0, 0, 1, 1, 'hC1, 0, 0, 1, 1, 0, 2, 0};
        tbl[20] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hC2, 0, 1, 0, 0, 0, 2, 1};
        tbl[21] = '{1, 'hB0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hC2, 0, 1, 0, 0, 0, 2, 1};
        tbl[22] = '{1, 'hB0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 'hC2, 0, 1, 1, 0, 0, 2, 1};
        tbl[23] = '{1, 'hB1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'hB0, 1, 0, 1, 0, 0, 2, 1};
        tbl[24] = '{1, 'hB1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 'hB0, 1, 0, 1, 0, 0, 2, 1};
        tbl[25] = '{1, 'hB1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 'hB0, 1, 0, 1, 0, 0, 2, 1};
        tbl[26] = '{1, 'hB2, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 'hB1, 0, 0, 1, 0, 0, 2, 1};
        tbl[27] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 'hB2, 0, 1, 0, 0, 0, 3, 1};
        tbl[28] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hB2, 0, 1, 0, 0, 0, 3, 1};
        tbl[29] = '{1, 'h11, 0, 0, 1, 'h22, 0, 0, 1, 1, 1, 1, 0, 'hB2, 0, 1, 0, 0, 0, 3, 1};
        tbl[30] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hB2, 0, 1, 0, 0, 1, 3, 1};
        tbl[31] = '{0, 'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 'hB2, 0, 1, 0, 0, 0, 3, 1};

        // Cycle table straight out of reset.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            ch0_valid = tbl[i].c0v; ch0_flit = tbl[i].c0f;
            ch0_is_header = tbl[i].c0h; ch0_is_tail = tbl[i].c0t;
            ch1_valid = tbl[i].c1v; ch1_flit = tbl[i].c1f;
            ch1_is_header = tbl[i].c1h; ch1_is_tail = tbl[i].c1t;
            out_ready = tbl[i].ordy; out_VCready = tbl[i].vc;
            #1;
            chk($sformatf("vec%0d", i),
                {8'h0, ch0_ready, ch1_ready, out_valid, out_flit, out_is_header, out_is_tail,
                 busy, owner, orphan_err, pkt_cnt0, pkt_cnt1},
                {8'h0, tbl[i].r0, tbl[i].r1, tbl[i].ov, tbl[i].f, tbl[i].h, tbl[i].t,
                 tbl[i].bsy, tbl[i].own, tbl[i].orph, tbl[i].n0, tbl[i].n1});
            @(negedge noc_clk);
        end

        // Contention from reset: ch0 wins, one idle cycle, ch1, then ch0 wins again.
        do_reset();
        vpct = 100; orpct = 100; vcpct = 100;
        q0.push_back(mk('hD0, 1, 0)); q0.push_back(mk('hD1, 0, 0));
        q0.push_back(mk('hD2, 0, 1)); q0.push_back(mk('hF0, 1, 1));
        q1.push_back(mk('hE0, 1, 0)); q1.push_back(mk('hE1, 0, 1));
        q1.push_back(mk('h60, 1, 1));
        ex = '{mk('hD0, 1, 0), mk('hD1, 0, 0), mk('hD2, 0, 1), mk('hE0, 1, 0),
               mk('hE1, 0, 1), mk('hF0, 1, 1), mk('h60, 1, 1)};
        first = -1; early = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (acc1 && first < 0) first = c;
            if (c < 5 && s_r1) early = 1'b1;
        end
        chk("cont_first_ch1_accept_cycle", first, 5);
        chk("cont_ch1_ready_during_ch0", early, 0);
        check_stream("cont");

        // Asynchronous reset in the middle of a packet, then a normal grant.
        do_reset();
        for (int k = 0; k < 4; k++) q0.push_back(mk('h90 + k, k == 0, k == 3));
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (acc0) n++;
        end
        chk("rst_two_flits_taken", n, 2);
        #2;
        noc_rst_n = 1'b0;
        #1;
        chk("rst_async_outputs",
            {out_valid, out_flit, out_is_header, out_is_tail, busy, owner, orphan_err,
             pkt_cnt0, pkt_cnt1}, 0);
        q0.delete();
        ch0_valid = 1'b0;
        @(negedge noc_clk);
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        obs.delete();
        q0.push_back(mk('h99, 1, 1));
        ex = '{mk('h99, 1, 1)};
        for (int c = 0; c < 20 && obs.size() < 1; c++) tick();
        tick();
        check_stream("rst_after");
        chk("rst_after_cnt0", s_c0, 1);

        // Counter wrap: 256 single-flit packets on ch1.
        do_reset();
        for (int i = 0; i < 256; i++) q1.push_back(mk(i, 1, 1));
        seen = 1'b0;
        for (int c = 0; c < 2000 && q1.size() > 0; c++) begin
            pre = q1.size();
            tick();
            if (pre == 1 && !seen) begin
                chk("wrap_cnt1_255", s_c1, 255);
                seen = 1'b1;
            end
        end
        chk("wrap_queue_drained", q1.size(), 0);
        tick();
        tick();
        chk("wrap_cnt1_zero", s_c1, 0);
        chk("wrap_nflits", obs.size(), 256);

        // Random run: both channels always present headers, so whole packets must alternate.
        do_reset();
        vpct = 70; orpct = 70; vcpct = 50;
        for (int p = 0; p < 40; p++) begin
            for (int ch = 0; ch < 2; ch++) begin
                int unsigned len;
                len = $urandom_range(4, 1);
                for (int unsigned k = 0; k < len; k++) begin
                    flit_t fl;
                    fl = mk($urandom, k == 0, k == len - 1);
                    if (ch == 0) q0.push_back(fl);
                    else q1.push_back(fl);
                    ex.push_back(fl);
                end
            end
        end
        orph_seen = 1'b0;
        for (int c = 0; c < 8000 && obs.size() < ex.size(); c++) begin
            tick();
            if (s_orph) orph_seen = 1'b1;
        end
        check_stream("rand");
        chk("rand_no_orphan", orph_seen, 0);
        tick();
        chk("rand_cnt0", s_c0, 40);
        chk("rand_cnt1", s_c1, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
